serial_adder_ctrl: RTL and testbench
====================================

# serial_adder_ctrl

Bit-serial addition controller built around a single 1-bit `full_adder` instance. It latches two WIDTH-bit operands and a carry-in on a start request. It then sequences the full adder LSB-first, one bit per clock, through a registered carry. It presents the WIDTH-bit sum and carry-out with a one-cycle `done` pulse. The block is the lab's multi-bit adder datapath controller: one shared 1-bit adder cell, reused over WIDTH cycles.

## Interface

Parameters:

- `WIDTH`, default 8: operand and result width in bits, WIDTH >= 1.

Ports:

- `clk`, input, 1: single clock, rising-edge active.
- `reset`, input, 1: asynchronous, active-high reset.
- `start`, input, 1: operation request; sampled only in IDLE.
- `op_a`, input, WIDTH: operand A; latched on accepted start.
- `op_b`, input, WIDTH: operand B; latched on accepted start.
- `cin`, input, 1: carry-in; latched on accepted start.
- `busy`, output, 1: high while bits are being added (SHIFT state).
- `done`, output, 1: one-cycle completion pulse (DONE state).
- `result`, output, WIDTH: registered sum; holds until the next completion.
- `cout`, output, 1: registered carry-out of bit WIDTH-1; holds with `result`.

## Operation

- Internal state:
  - operand shift registers `a_sh` and `b_sh` (WIDTH each);
  - sum shift register `s_sh` (WIDTH);
  - carry flip-flop `c_q`;
  - bit counter `cnt` of width $clog2(WIDTH+1);
  - FSM state.
- Datapath: the `full_adder` instance has a = `a_sh[0]`, b = `b_sh[0]`, c = `c_q`.
  - Its sum shifts into the MSB of `s_sh`.
  - Its carry loads `c_q`.
  - `a_sh` and `b_sh` shift right by 1.
- FSM states: IDLE, SHIFT, DONE. Encoding is free; no other reachable states.
- IDLE:
  - If `start`=1 at a rising edge: load `a_sh`=op_a, `b_sh`=op_b, `c_q`=cin, `cnt`=0, and go to SHIFT.
  - Otherwise stay in IDLE.
- SHIFT, at each edge:
  - Perform one bit step and increment `cnt`.
  - When the step with `cnt`=WIDTH-1 completes, go to DONE. At that same edge, load `result` with the final `s_sh` contents (including the bit just computed) and `cout` with the new carry.
- DONE: unconditionally return to IDLE at the next edge.
- `start` is ignored in SHIFT and DONE. There is no queueing; the requester must re-assert `start` in IDLE.
- Operand inputs are don't-care after the accepting edge. Changing them mid-operation does not affect the result.
- Arithmetic: {cout, result} = op_a + op_b + cin, computed as a (WIDTH+1)-bit value. `result` wraps modulo 2^WIDTH.
- WIDTH=1: SHIFT lasts exactly one cycle.
- Outputs:
  - `busy` = (state==SHIFT).
  - `done` = (state==DONE).
  - Both are decoded from registered state; no combinational path from inputs.
- Reset, asynchronous, at any time including mid-operation:
  - state=IDLE; all shift registers, `c_q`, and `cnt` cleared.
  - `busy`=0, `done`=0, `result`=0, `cout`=0.
  - An aborted operation produces no `done` and does not update `result` or `cout`.
  - After reset deassertion, the first rising edge may accept `start`.

## Timing

- Let E0 be the edge that accepts `start`.
  - Edges E1..E(WIDTH) perform bit steps 0..WIDTH-1.
  - `busy`=1 in the cycles between E0 and E(WIDTH).
- `result` and `cout` update at E(WIDTH). `done`=1 for exactly the cycle between E(WIDTH) and E(WIDTH+1).
- Latency: `done` rises WIDTH cycles after the accepting edge. Total occupancy is WIDTH+1 cycles.
- Throughput: with `start` held high continuously, operations are accepted every WIDTH+2 cycles, at E0, E(WIDTH+2), and so on.
- `result` and `cout` are stable from E(WIDTH) until the next completion edge. They are not disturbed by the next start or by SHIFT activity.

## Test plan

- WIDTH=8, reset, then op_a=0x03, op_b=0x05, cin=0, pulse start:
  - `busy` high for 8 cycles, then `done` for 1 cycle;
  - result=0x08, cout=0.
- op_a=0xFF, op_b=0x01, cin=0 → result=0x00, cout=1. Then op_a=0xFF, op_b=0xFF, cin=1 → result=0xFF, cout=1.
- `start` held high with op_a=0x10, op_b=0x20, cin=0:
  - `done` pulses every 10 cycles;
  - result=0x30 each time;
  - `done` is never high for two consecutive cycles.
- Accept op_a=0x0A, op_b=0x05, then during SHIFT change the operands to 0xFF and pulse `start` again:
  - result=0x0F;
  - only one `done` pulse for that operation.
- Start op_a=0x7F, op_b=0x01, then assert `reset` asynchronously in the middle of the 3rd SHIFT cycle:
  - `busy`=0 immediately;
  - no `done`;
  - result=0x00, cout=0;
  - a subsequent start with 0x02+0x02 gives result=0x04.
- WIDTH=1 instance:
  - 1+1+1 → result=1, cout=1, with `busy` high for exactly 1 cycle;
  - 0+0+0 → result=0, cout=0.

Source files
------------

// File: rtl/serial_adder_ctrl.sv
// rtl/serial_adder_ctrl.sv - bit-serial adder controller reusing one full_adder cell
// Operands shift out LSB-first through a single full adder; the sum shifts in MSB-first.

module full_adder (
   input  logic a,
   input  logic b,
   input  logic c,
   output logic s,
   output logic co
);
   assign s  = a ^ b ^ c;
   assign co = (a & b) | (a & c) | (b & c);
endmodule

module serial_adder_ctrl #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [WIDTH-1:0] op_a,
   input  logic [WIDTH-1:0] op_b,
   input  logic             cin,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] result,
   output logic             cout
);
   localparam int CW = $clog2(WIDTH + 1);

   typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

   state_t           state, state_nxt;
   logic [WIDTH-1:0] a_sh, b_sh, s_sh, s_nxt;
   logic             c_q;
   logic [CW-1:0]    cnt;
   logic             fa_s, fa_c;
   logic             last;

   full_adder u_fa (
      .a  (a_sh[0]),
      .b  (b_sh[0]),
      .c  (c_q),
      .s  (fa_s),
      .co (fa_c)
   );

   assign last = (cnt == CW'(WIDTH - 1));
   assign busy = (state == SHIFT);
   assign done = (state == DONE);

   // Shift-and-insert form stays legal when WIDTH is 1.
   always_comb begin
      s_nxt = s_sh >> 1;
      s_nxt[WIDTH-1] = fa_s;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (start) state_nxt = SHIFT;
         SHIFT:   if (last) state_nxt = DONE;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         a_sh   <= '0;
         b_sh   <= '0;
         s_sh   <= '0;
         c_q    <= 1'b0;
         cnt    <= '0;
         result <= '0;
         cout   <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  a_sh <= op_a;
                  b_sh <= op_b;
                  c_q  <= cin;
                  cnt  <= '0;
               end
            end
            SHIFT: begin
               a_sh <= a_sh >> 1;
               b_sh <= b_sh >> 1;
               s_sh <= s_nxt;
               c_q  <= fa_c;
               cnt  <= cnt + 1'b1;
               // Publish on the final step so result never shows a partial sum.
               if (last) begin
                  result <= s_nxt;
                  cout   <= fa_c;
               end
            end
            default: ;
         endcase
      end
   end
endmodule

// File: tb/tb_serial_adder_ctrl.sv
// tb/tb_serial_adder_ctrl.sv - scoreboard bench for serial_adder_ctrl at WIDTH 8 and 1

module tb_serial_adder_ctrl;
   logic       clk = 1'b0;
   logic       reset;
   logic       start8, c8, busy8, done8, cout8;
   logic [7:0] a8, b8, result8;
   logic       start1, a1, b1, c1, busy1, done1, result1, cout1;

   int n_tests = 0;
   int n_fail  = 0;
   int dn8 = 0;
   int dn1 = 0;
   logic prev8 = 1'b0;
   logic prev1 = 1'b0;
   logic [8:0] sb8[$];
   logic [1:0] sb1[$];

   always #5 clk = ~clk;

   serial_adder_ctrl #(.WIDTH(8)) dut8 (
      .clk(clk), .reset(reset), .start(start8), .op_a(a8), .op_b(b8), .cin(c8),
      .busy(busy8), .done(done8), .result(result8), .cout(cout8)
   );

   serial_adder_ctrl #(.WIDTH(1)) dut1 (
      .clk(clk), .reset(reset), .start(start1), .op_a(a1), .op_b(b1), .cin(c1),
      .busy(busy1), .done(done1), .result(result1), .cout(cout1)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   always @(negedge clk) begin
      if (!reset) begin
         if (done8) begin
            dn8 <= dn8 + 1;
            check("done8_single", 32'(prev8), 0);
            check("sb8_pending", 32'(sb8.size() != 0), 1);
            if (sb8.size() != 0) check("sum8", 32'({cout8, result8}), 32'(sb8.pop_front()));
         end
         if (done1) begin
            dn1 <= dn1 + 1;
            check("done1_single", 32'(prev1), 0);
            check("sb1_pending", 32'(sb1.size() != 0), 1);
            if (sb1.size() != 0) check("sum1", 32'({cout1, result1}), 32'(sb1.pop_front()));
         end
      end
      prev8 <= done8;
      prev1 <= done1;
   end

   task automatic run8(input logic [7:0] a, input logic [7:0] b, input logic c, input bit mid_change);
      int nb = 0;
      int seen = 0;
      int d0;
      @(negedge clk);
      a8 = a; b8 = b; c8 = c; start8 = 1'b1;
      sb8.push_back({1'b0, a} + {1'b0, b} + {8'd0, c});
      d0 = dn8;
      for (int i = 0; i < 40 && seen == 0; i++) begin
         @(negedge clk);
         if (i == 0) begin
            if (mid_change) begin a8 = 8'hFF; b8 = 8'hFF; end
            else start8 = 1'b0;
         end
         if (i == 2) start8 = 1'b0;
         if (busy8) nb++;
         if (done8) seen = 1;
      end
      check("busy8_cycles", nb, 8);
      check("done8_seen", seen, 1);
      repeat (3) @(negedge clk);
      check("done8_count", dn8 - d0, 1);
   endtask

   task automatic run1(input logic a, input logic b, input logic c);
      int nb = 0;
      int seen = 0;
      @(negedge clk);
      a1 = a; b1 = b; c1 = c; start1 = 1'b1;
      sb1.push_back({1'b0, a} + {1'b0, b} + {1'b0, c});
      for (int i = 0; i < 20 && seen == 0; i++) begin
         @(negedge clk);
         start1 = 1'b0;
         if (busy1) nb++;
         if (done1) seen = 1;
      end
      check("busy1_cycles", nb, 1);
      check("done1_seen", seen, 1);
      repeat (2) @(negedge clk);
   endtask

   initial begin
      int ndone = 0;
      int last = -1;
      int dr;
      reset = 1'b1;
      start8 = 1'b0; a8 = '0; b8 = '0; c8 = 1'b0;
      start1 = 1'b0; a1 = 1'b0; b1 = 1'b0; c1 = 1'b0;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      #1;
      check("rst_busy8", busy8, 0);
      check("rst_done8", done8, 0);
      check("rst_result8", result8, 0);
      check("rst_cout8", cout8, 0);
      check("rst_busy1", busy1, 0);
      check("rst_result1", result1, 0);

      run8(8'h03, 8'h05, 1'b0, 1'b0);
      run8(8'hFF, 8'h01, 1'b0, 1'b0);
      run8(8'hFF, 8'hFF, 1'b1, 1'b0);

      // Held start: one acceptance every WIDTH+2 cycles.
      @(negedge clk);
      a8 = 8'h10; b8 = 8'h20; c8 = 1'b0; start8 = 1'b1;
      repeat (3) sb8.push_back(9'h030);
      for (int i = 0; i < 60 && ndone < 3; i++) begin
         @(negedge clk);
         if (done8) begin
            if (last >= 0) check("done8_period", i - last, 10);
            last = i;
            ndone++;
            if (ndone == 3) start8 = 1'b0;
         end
      end
      check("held_done_count", ndone, 3);
      repeat (2) @(negedge clk);

      run8(8'h0A, 8'h05, 1'b0, 1'b1);

      // Abort mid-operation: reset in the middle of the third SHIFT cycle.
      @(negedge clk);
      a8 = 8'h7F; b8 = 8'h01; c8 = 1'b0; start8 = 1'b1;
      @(negedge clk);
      start8 = 1'b0;
      repeat (2) @(negedge clk);
      check("pre_abort_busy8", busy8, 1);
      reset = 1'b1;
      #1;
      check("abort_busy8", busy8, 0);
      check("abort_done8", done8, 0);
      check("abort_result8", result8, 0);
      check("abort_cout8", cout8, 0);
      dr = dn8;
      @(negedge clk);
      reset = 1'b0;
      repeat (12) @(negedge clk);
      check("abort_no_done", dn8 - dr, 0);
      check("abort_result_hold", result8, 0);
      run8(8'h02, 8'h02, 1'b0, 1'b0);

      run1(1'b1, 1'b1, 1'b1);
      run1(1'b0, 1'b0, 1'b0);
      run1(1'b1, 1'b0, 1'b0);

      repeat (3) @(negedge clk);
      check("sb8_drained", sb8.size(), 0);
      check("sb1_drained", sb1.size(), 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
